// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 constants, FSM states and latched address-channel bundle
// for the io_slave scratchpad responder.
package ysyx_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_req_t;

endpackage

// File: rtl/ysyx_axi_burst_addr.sv
// Next-beat address and burst legality for one AXI channel.
// YSYX_AXI_SLAVE_WRAP_EN enables WRAP bursts; otherwise WRAP is illegal.
module ysyx_axi_burst_addr
    import ysyx_axi_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      size,
    input  logic [7:0]      len,
    input  logic [1:0]      burst,
    output logic [XLEN-1:0] next_addr,
    output logic            legal
);

`ifdef YSYX_AXI_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] incr;
    logic [XLEN-1:0] mask;
    logic            len_ok;
    logic            aligned;

    assign step    = XLEN'(1) << size;
    assign incr    = addr + step;
    // Container is (len+1)<<size bytes; the address wraps inside it.
    assign mask    = ((XLEN'(len) + XLEN'(1)) << size) - XLEN'(1);
    assign len_ok  = (len == 8'd1) || (len == 8'd3) ||
                     (len == 8'd7) || (len == 8'd15);
    assign aligned = (addr & (step - XLEN'(1))) == '0;

    always_comb begin
        next_addr = incr;
        legal     = 1'b0;
        unique case (1'b1)
            burst == AXI_BURST_FIXED: begin
                next_addr = addr;
                legal     = 1'b1;
            end
            burst == AXI_BURST_INCR: begin
                legal = 1'b1;
            end
            burst == AXI_BURST_WRAP: begin
                if (WRAP_EN) begin
                    next_addr = (addr & ~mask) | (incr & mask);
                end
                legal = WRAP_EN && len_ok && aligned;
            end
            default: ;
        endcase
        if (size > 3'd2) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_axi4_slave_spm.sv
// AXI4 scratchpad responder terminating the core's io_slave port.
// Define YSYX_AXI_SLAVE_WRAP_EN to accept WRAP bursts.
module ysyx_axi4_slave_spm
    import ysyx_axi_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0f00_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      io_slave_arburst,
    input  logic [2:0]      io_slave_arsize,
    input  logic [7:0]      io_slave_arlen,
    input  logic [3:0]      io_slave_arid,
    input  logic [XLEN-1:0] io_slave_araddr,
    input  logic            io_slave_arvalid,
    output logic            io_slave_arready,
    output logic [3:0]      io_slave_rid,
    output logic            io_slave_rlast,
    output logic [XLEN-1:0] io_slave_rdata,
    output logic [1:0]      io_slave_rresp,
    output logic            io_slave_rvalid,
    input  logic            io_slave_rready,
    input  logic [1:0]      io_slave_awburst,
    input  logic [2:0]      io_slave_awsize,
    input  logic [7:0]      io_slave_awlen,
    input  logic [3:0]      io_slave_awid,
    input  logic [XLEN-1:0] io_slave_awaddr,
    input  logic            io_slave_awvalid,
    output logic            io_slave_awready,
    input  logic            io_slave_wlast,
    input  logic [XLEN-1:0] io_slave_wdata,
    input  logic [3:0]      io_slave_wstrb,
    input  logic            io_slave_wvalid,
    output logic            io_slave_wready,
    output logic [3:0]      io_slave_bid,
    output logic [1:0]      io_slave_bresp,
    output logic            io_slave_bvalid,
    input  logic            io_slave_bready
);

    localparam int              IDXW = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH_WORDS);

    function automatic logic in_range(input logic [XLEN-1:0] a);
        in_range = (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDXW-1:0] widx(input logic [XLEN-1:0] a);
        widx = IDXW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    rd_state_e       rs;
    ax_req_t         rreq;
    ax_req_t         r_cur;
    logic [7:0]      rcnt;
    logic [XLEN-1:0] r_next;
    logic            r_legal;
    logic [XLEN-1:0] r_beat_addr;
    logic            r_ok;
    logic [XLEN-1:0] r_word;
    logic [1:0]      r_resp;

    wr_state_e       ws;
    ax_req_t         wreq;
    logic [7:0]      wcnt;
    logic            werr;
    logic [XLEN-1:0] w_next;
    logic            w_legal;
    logic            w_ok;
    logic            w_bad;

    // In idle the AR inputs feed the address unit so beat 0 is fetched on the handshake.
    always_comb begin
        r_cur = rreq;
        if (rs == R_IDLE) begin
            r_cur = '{id: io_slave_arid, addr: io_slave_araddr,
                      len: io_slave_arlen, size: io_slave_arsize,
                      burst: io_slave_arburst};
        end
    end

    ysyx_axi_burst_addr #(.XLEN(XLEN)) u_rd_addr (
        .addr      (r_cur.addr),
        .size      (r_cur.size),
        .len       (r_cur.len),
        .burst     (r_cur.burst),
        .next_addr (r_next),
        .legal     (r_legal)
    );

    ysyx_axi_burst_addr #(.XLEN(XLEN)) u_wr_addr (
        .addr      (wreq.addr),
        .size      (wreq.size),
        .len       (wreq.len),
        .burst     (wreq.burst),
        .next_addr (w_next),
        .legal     (w_legal)
    );

    assign r_beat_addr  = (rs == R_IDLE) ? r_cur.addr : r_next;
    assign r_ok         = r_legal && in_range(r_beat_addr);
    assign r_word       = r_ok ? mem[widx(r_beat_addr)] : '0;
    assign r_resp       = r_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    assign io_slave_rid = rreq.id;

    assign w_ok         = w_legal && in_range(wreq.addr);
    assign w_bad        = !w_ok || (io_slave_wlast != (wcnt == wreq.len));
    assign io_slave_bid = wreq.id;

    always_ff @(posedge clock) begin
        if (io_slave_wready && io_slave_wvalid && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) begin
                    mem[widx(wreq.addr)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs               <= R_IDLE;
            rreq             <= '0;
            rcnt             <= '0;
            io_slave_arready <= 1'b0;
            io_slave_rvalid  <= 1'b0;
            io_slave_rlast   <= 1'b0;
            io_slave_rdata   <= '0;
            io_slave_rresp   <= AXI_RESP_OKAY;
        end else begin
            unique case (rs)
                R_IDLE: begin
                    io_slave_arready <= 1'b1;
                    if (io_slave_arready && io_slave_arvalid) begin
                        rs               <= R_DATA;
                        rreq             <= r_cur;
                        rcnt             <= '0;
                        io_slave_arready <= 1'b0;
                        io_slave_rvalid  <= 1'b1;
                        io_slave_rlast   <= (io_slave_arlen == 8'd0);
                        io_slave_rdata   <= r_word;
                        io_slave_rresp   <= r_resp;
                    end
                end
                R_DATA: begin
                    if (io_slave_rready) begin
                        if (io_slave_rlast) begin
                            rs               <= R_IDLE;
                            io_slave_rvalid  <= 1'b0;
                            io_slave_rlast   <= 1'b0;
                            io_slave_arready <= 1'b1;
                        end else begin
                            rreq.addr      <= r_next;
                            rcnt           <= rcnt + 8'd1;
                            io_slave_rlast <= (rcnt + 8'd1 == rreq.len);
                            io_slave_rdata <= r_word;
                            io_slave_rresp <= r_resp;
                        end
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ws               <= W_IDLE;
            wreq             <= '0;
            wcnt             <= '0;
            werr             <= 1'b0;
            io_slave_awready <= 1'b0;
            io_slave_wready  <= 1'b0;
            io_slave_bvalid  <= 1'b0;
            io_slave_bresp   <= AXI_RESP_OKAY;
        end else begin
            unique case (ws)
                W_IDLE: begin
                    io_slave_awready <= 1'b1;
                    if (io_slave_awready && io_slave_awvalid) begin
                        ws               <= W_DATA;
                        wreq             <= '{id: io_slave_awid, addr: io_slave_awaddr,
                                              len: io_slave_awlen, size: io_slave_awsize,
                                              burst: io_slave_awburst};
                        wcnt             <= '0;
                        werr             <= 1'b0;
                        io_slave_awready <= 1'b0;
                        io_slave_wready  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (io_slave_wvalid) begin
                        wreq.addr <= w_next;
                        wcnt      <= wcnt + 8'd1;
                        werr      <= werr | w_bad;
                        if (wcnt == wreq.len) begin
                            ws              <= W_RESP;
                            io_slave_wready <= 1'b0;
                            io_slave_bvalid <= 1'b1;
                            io_slave_bresp  <= (werr || w_bad) ? AXI_RESP_SLVERR
                                                               : AXI_RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (io_slave_bready) begin
                        ws               <= W_IDLE;
                        io_slave_bvalid  <= 1'b0;
                        io_slave_awready <= 1'b1;
                    end
                end
                default: ws <= W_IDLE;
            endcase
        end
    end

endmodule
